// File: rtl/sev_seg_countdown_ctrl.sv
// sev_seg_countdown_ctrl: Avalon-MM seven-segment driver with a BCD capture countdown
module sev_seg_countdown_ctrl #(
  parameter int TICK_DIV   = 50000000,
  parameter int HOLD_TICKS = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [19:0] out_port,
  output logic        irq
);
  typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;
  state_t      state_q, state_d;
  logic [19:0] direct_q, direct_d;
  logic [7:0]  start_q, start_d, count_q, count_d, hold_q, hold_d;
  logic [31:0] presc_q, presc_d;
  logic        irq_en_q, irq_en_d, done_q, done_d;
  logic        wr, busy, tick, go_start, go_abort;
  function automatic logic [3:0] clamp(input logic [3:0] n);
    return n > 4'd9 ? 4'd9 : n;
  endfunction
  assign wr       = chipselect & ~write_n;
  assign busy     = state_q != IDLE;
  assign tick     = presc_q == 32'(TICK_DIV - 1);
  assign go_abort = wr && address == 2'd2 && writedata[1] && busy;
  assign go_start = wr && address == 2'd2 && writedata[0] && !go_abort;
  assign irq      = done_q & irq_en_q;
  assign out_port = !busy ? direct_q : {direct_q[19:8], state_q == COUNT ? count_q : 8'h00};
  assign readdata = address == 2'd0 ? {12'd0, direct_q} :
                    address == 2'd1 ? {24'd0, start_q} :
                    {29'd0, irq_en_q, done_q, busy};
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    hold_d   = hold_q;
    presc_d  = presc_q;
    direct_d = (wr && address == 2'd0) ? writedata[19:0] : direct_q;
    start_d  = (wr && address == 2'd1) ? {clamp(writedata[7:4]), clamp(writedata[3:0])} : start_q;
    irq_en_d = (wr && address == 2'd2) ? writedata[2] : irq_en_q;
    done_d   = (wr && address == 2'd3 && writedata[1]) ? 1'b0 : done_q;
    if (go_abort) begin
      state_d = IDLE;
      presc_d = '0;
    end else if (go_start) begin
      state_d = start_q == 8'h00 ? HOLD : COUNT;
      count_d = start_q;
      presc_d = '0;
      hold_d  = '0;
      done_d  = 1'b0;
    end else if (busy) begin
      presc_d = tick ? '0 : presc_q + 32'd1;
      if (tick && state_q == COUNT) begin
        // 01 is the last visible digit: show 00 and enter the hold phase
        state_d = count_q == 8'h01 ? HOLD : COUNT;
        hold_d  = count_q == 8'h01 ? 8'd0 : hold_q;
        count_d = count_q == 8'h01 ? 8'h00 :
                  count_q[3:0] == 4'd0 ? {count_q[7:4] - 4'd1, 4'd9} :
                  {count_q[7:4], count_q[3:0] - 4'd1};
      end else if (tick) begin
        hold_d  = hold_q + 8'd1;
        state_d = hold_q == 8'(HOLD_TICKS - 1) ? IDLE : HOLD;
        done_d  = hold_q == 8'(HOLD_TICKS - 1) ? 1'b1 : done_d;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      direct_q <= '0;
      start_q  <= 8'h03;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      presc_q  <= '0;
      count_q  <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      direct_q <= direct_d;
      start_q  <= start_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      presc_q  <= presc_d;
      count_q  <= count_d;
      hold_q   <= hold_d;
    end
  end
endmodule
